// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared constants and state types for the word memory bus
package mem_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    RECOVER
  } state_e;

  // PTR: fetching the pointer word; FINAL: the access the request asked for
  typedef enum logic {
    PTR,
    FINAL
  } phase_e;

endpackage

// File: rtl/mem_master_if.sv
// rtl/mem_master_if.sv - CPU request side and memory pin side of mem_master
interface mem_master_if #(
  parameter int ADDR_W = mem_pkg::ADDR_W,
  parameter int DATA_W = mem_pkg::DATA_W
);

  logic              req;
  logic              wr;
  logic              indirect;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ack;
  logic              busy;
  logic [ADDR_W-1:0] i;
  logic [DATA_W-1:0] memin;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] memout;

  modport master (
    input  req, wr, indirect, addr, wdata, memout,
    output rdata, ack, busy, i, memin, read, write
  );

  modport slave (
    output req, wr, indirect, addr, wdata, memout,
    input  rdata, ack, busy, i, memin, read, write
  );

endinterface

// File: rtl/mem_master.sv
// rtl/mem_master.sv - single-request memory initiator with setup/strobe/recover
// sequencing and optional one-level pointer indirection
module mem_master
  import mem_pkg::*;
#(
  parameter int ADDR_W = mem_pkg::ADDR_W,
  parameter int DATA_W = mem_pkg::DATA_W
) (
  input  logic             clk,
  input  logic             rst_n,
  mem_master_if.master     bus
);

  state_e            state_q;
  phase_e            phase_q;
  logic              wr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] memin_q;
  logic [ADDR_W-1:0] i_q;
  logic              ack_q;
  logic              busy_q;
  logic              read_q;
  logic              write_q;

  // All pin outputs are registered so strobes are glitch-free and the
  // asynchronous reset drops them without a spurious rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      phase_q <= FINAL;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      ptr_q   <= '0;
      rdata_q <= '0;
      memin_q <= '0;
      i_q     <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.req) begin
            wr_q    <= bus.wr;
            wdata_q <= bus.wdata;
            i_q     <= bus.addr;
            phase_q <= bus.indirect ? PTR : FINAL;
            if (bus.wr && !bus.indirect) begin
              memin_q <= bus.wdata;
            end
            busy_q  <= 1'b1;
            state_q <= SETUP;
          end
        end
        SETUP: begin
          read_q  <= (phase_q == PTR) || !wr_q;
          write_q <= (phase_q == FINAL) && wr_q;
          state_q <= STROBE;
        end
        STROBE: begin
          read_q  <= 1'b0;
          write_q <= 1'b0;
          if (phase_q == PTR) begin
            ptr_q <= bus.memout[ADDR_W-1:0];
          end else begin
            ack_q <= 1'b1;
            if (!wr_q) begin
              rdata_q <= bus.memout;
            end
          end
          state_q <= RECOVER;
        end
        RECOVER: begin
          if (phase_q == PTR) begin
            i_q     <= ptr_q;
            phase_q <= FINAL;
            if (wr_q) begin
              memin_q <= wdata_q;
            end
            state_q <= SETUP;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.rdata = rdata_q;
  assign bus.ack   = ack_q;
  assign bus.busy  = busy_q;
  assign bus.i     = i_q;
  assign bus.memin = memin_q;
  assign bus.read  = read_q;
  assign bus.write = write_q;

endmodule

// File: doc/mem_master.md
# mem_master

Initiator side of the edge-strobed word memory bus: accepts one read or write request at a time from CPU control, drives the memory's `i`, `memin`, `read` and `write` pins with a fixed setup/strobe/recover sequence, and returns read data with a one-cycle `ack`. It optionally performs one level of indirection: it fetches a pointer word, then accesses the address held in its low bits. It sits between the CPU sequencer/register file and the memory, and is the only driver of the memory strobes.

## Interface
- `ADDR_W`, 12, address width; also the number of pointer bits used for indirection
- `DATA_W`, 16, word width
- `clk  in  1  single clock; all state changes on rising edge`
- `rst_n  in  1  asynchronous, active-low reset`
- `req  in  1  start request; sampled only in IDLE`
- `wr  in  1  1 = write, 0 = read; captured with req`
- `indirect  in  1  1 = resolve pointer at addr first; captured with req`
- `addr  in  ADDR_W  request address; captured with req`
- `wdata  in  DATA_W  write data; captured with req`
- `rdata  out  DATA_W  data from the last completed read`
- `ack  out  1  one-cycle completion pulse`
- `busy  out  1  high from the cycle after req is accepted until ack`
- `i  out  ADDR_W  memory address`
- `memin  out  DATA_W  memory write data`
- `read  out  1  memory read strobe; memory acts on its rising edge`
- `write  out  1  memory write strobe; memory acts on its rising edge`
- `memout  in  DATA_W  memory read data`

## Operation
- States: IDLE, SETUP, STROBE, RECOVER.
- IDLE: on `req`=1, latch `wr`, `indirect`, `addr`, `wdata`. Set phase = PTR if `indirect`, else FINAL. Go to SETUP.
- SETUP: drive `i` = current address. For a FINAL write, also drive `memin` = latched wdata. Both strobes are 0. Go to STROBE.
- STROBE: raise `read` (PTR phase or FINAL read) or `write` (FINAL write); exactly one strobe is high. `i` and `memin` are held. Go to RECOVER.
- RECOVER: strobes are 0. `i` and `memin` are held.
  - PTR phase: current address := captured word[ADDR_W-1:0], phase := FINAL, go to SETUP. No `ack`.
  - FINAL phase: `ack`=1 for this cycle only, go to IDLE.
- Read data is captured from `memout` on the clock edge leaving STROBE. In PTR phase it goes to an internal pointer register. In FINAL read it goes to `rdata`.
- `rdata` changes only on a FINAL read. It is unchanged by writes and by pointer fetches.
- `req` outside IDLE is ignored. Requests are not queued.
- Every strobe pulse is preceded and followed by at least one low cycle, so each access produces exactly one rising edge.
- `read` and `write` are never high together.

## Timing
- Reset values: `rdata`=0, `ack`=0, `busy`=0, `i`=0, `memin`=0, `read`=0, `write`=0; state = IDLE.
- `req` sampled at edge E0 (direct access):
  - SETUP at E0–E1
  - strobe high at E1–E2
  - RECOVER with `ack`=1 at E2–E3
  - Latency is 3 cycles.
- Indirect access: `ack` at E5–E6 (6 cycles). The strobe of the second access is high at E4–E5.
- Back-to-back: `req` high during the `ack` cycle is not accepted; the earliest new acceptance is the edge after `ack`. This gives a minimum 4-cycle period and a guaranteed strobe low gap of 2 or more cycles.
- `busy` goes high at E0 and drops together with `ack`.
- Reset asserted mid-access: all outputs go immediately to reset values, including a high strobe falling (no spurious rising edge). The in-flight request is discarded, and no `ack` is produced.
- Pointer width rule: only the low ADDR_W bits of the pointer word are used; the upper bits are ignored.

## Structure
- Shared package `mem_pkg`:
  - state enum (IDLE, SETUP, STROBE, RECOVER)
  - phase enum (PTR, FINAL)
  - default ADDR_W=12, DATA_W=16
- The memory model consumes the same package constants.
- Single module; no sub-module. The FSM, request latch and capture registers all stay in `mem_master`.

## Test plan
The bench memory model is preloaded with word 2 = 16'h0005, word 5 = 16'h1234, word 7 = 16'hf004.
- Direct read of addr 5 -> `ack` 3 cycles after `req`; `rdata`=16'h1234; `read` high for exactly 1 cycle; `write` never high.
- Direct write of 16'hbeef to addr 3, then direct read of addr 3 -> `rdata`=16'hbeef; `memin`=16'hbeef throughout SETUP–RECOVER of the write.
- Indirect read at addr 2 -> two `read` pulses at `i`=2 then `i`=5; `ack` 6 cycles after `req`; `rdata`=16'h1234.
- Indirect write of 16'h00aa via addr 7 (pointer 16'hf004, upper bits ignored) -> `write` at `i`=4; word 4 = 16'h00aa; `rdata` unchanged.
- `req` held high continuously for two direct reads (addr 5, then addr 2) -> second acceptance at the edge after the first `ack`; strobe low gap of 2 or more cycles; `rdata`=16'h0005 after the second `ack`.
- `rst_n` pulsed low while `read` is high -> `read`, `busy` and `ack` drop immediately; no `ack` follows; the next request completes normally.
